// File: rtl/fp_round_pack_if.sv
// Handshake bundle for fp_round_pack: raw product beat in, packed IEEE-754 word out.
interface fp_round_pack_if #(
  parameter int EXP_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [47:0]             in_mant;
  logic                    in_nan;
  logic                    in_inf;
  logic                    in_zero;

  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_z;
  logic                    nan;
  logic                    overflow;
  logic                    underflow;
  logic                    zero;
  logic                    inexact;

  // The rounding stage is the slave of the upstream multiplier.
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_z, nan, overflow, underflow, zero, inexact
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_z, nan, overflow, underflow, zero, inexact
  );
endinterface

// File: rtl/fp_round_pack.sv
// Normalize / round-to-nearest-even / pack stage behind the 24x24 significand multiplier.
// Two register stages with a valid/ready skid-free pipeline (throughput one beat per clock).
module fp_round_pack #(
  parameter int EXP_W    = 10,
  parameter bit FLUSH_UF = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_round_pack_if.slave  bus
);

  localparam int EW = EXP_W + 1;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_NIL  = '0;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(255);

  function automatic logic [24:0] round_ne(input logic [23:0] sig, input logic g,
                                           input logic s);
    logic up;
    up = g & (s | sig[0]);
    return {1'b0, sig} + {24'b0, up};
  endfunction

  function automatic logic [31:0] pack(input logic sign, input logic [7:0] e,
                                       input logic [22:0] frac);
    return {sign, e, frac};
  endfunction

  logic adv1, adv2;

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [23:0]          s1_sig_q;
  logic                 s1_g_q;
  logic                 s1_s_q;
  logic                 s1_nan_q;
  logic                 s1_inf_q;
  logic                 s1_zero_q;

  logic signed [EW-1:0] s1_exp_d;
  logic [23:0]          s1_sig_d;
  logic                 s1_g_d;
  logic                 s1_s_d;
  logic signed [EW-1:0] in_exp_ext;

  logic                 s2_valid_q;
  logic [31:0]          z_q;
  logic                 nan_q, ovf_q, unf_q, zero_q, inx_q;

  logic [31:0]          z_d;
  logic                 nan_d, ovf_d, unf_d, zero_d, inx_d;
  logic [24:0]          rnd;
  logic signed [EW-1:0] e_rnd;
  logic [22:0]          frac;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  assign in_exp_ext = {bus.in_exp[EXP_W-1], bus.in_exp};

  // ---- stage 1: normalize to a 24-bit significand with guard and sticky
  always_comb begin
    s1_sig_d = bus.in_mant[46:23];
    s1_g_d   = bus.in_mant[22];
    s1_s_d   = |bus.in_mant[21:0];
    s1_exp_d = in_exp_ext;
    if (bus.in_mant[47]) begin
      s1_sig_d = bus.in_mant[47:24];
      s1_g_d   = bus.in_mant[23];
      s1_s_d   = |bus.in_mant[22:0];
      s1_exp_d = in_exp_ext + EXP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q <= bus.in_sign;
        s1_exp_q  <= s1_exp_d;
        s1_sig_q  <= s1_sig_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_nan_q  <= bus.in_nan;
        s1_inf_q  <= bus.in_inf;
        s1_zero_q <= bus.in_zero;
      end
    end
  end

  // ---- stage 2: round, classify and pack
  always_comb begin
    rnd    = round_ne(s1_sig_q, s1_g_q, s1_s_q);
    e_rnd  = s1_exp_q + (rnd[24] ? EXP_ONE : EXP_NIL);
    // A rounding carry leaves 1.000..0, so the stored fraction is all zero.
    frac   = rnd[24] ? 23'b0 : rnd[22:0];
    z_d    = pack(s1_sign_q, e_rnd[7:0], frac);
    nan_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    inx_d  = s1_g_q | s1_s_q;
    if (s1_nan_q) begin
      z_d   = 32'h7FC0_0000;
      nan_d = 1'b1;
      inx_d = 1'b0;
    end else if (s1_inf_q) begin
      z_d   = pack(s1_sign_q, 8'hFF, 23'b0);
      ovf_d = 1'b1;
      inx_d = 1'b0;
    end else if (s1_zero_q) begin
      z_d    = pack(s1_sign_q, 8'h00, 23'b0);
      zero_d = 1'b1;
      inx_d  = 1'b0;
    end else if (e_rnd >= EXP_MAX) begin
      z_d   = pack(s1_sign_q, 8'hFF, 23'b0);
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (FLUSH_UF && (e_rnd <= EXP_NIL)) begin
      z_d    = pack(s1_sign_q, 8'h00, 23'b0);
      unf_d  = 1'b1;
      zero_d = 1'b1;
      inx_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      nan_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
      inx_q      <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        z_q    <= z_d;
        nan_q  <= nan_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        zero_q <= zero_d;
        inx_q  <= inx_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_z     = z_q;
  assign bus.nan       = nan_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.zero      = zero_q;
  assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed corner cases, stall/reset sequences and
// randomized traffic scored against an arithmetic rounding model.
module tb_fp_round_pack;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  f;   // {nan, overflow, underflow, zero, inexact}
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dir_rdy = 1'b1;
  logic rnd_mode = 1'b0;
  logic rnd_rdy = 1'b1;

  int errors = 0;
  int checks = 0;

  res_t exp_q[$];
  res_t obs_q[$];

  fp_round_pack_if #(.EXP_W(10)) bus();

  fp_round_pack #(.EXP_W(10), .FLUSH_UF(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rnd_mode ? rnd_rdy : dir_rdy;

  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  always @(negedge clk) begin
    res_t o;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      o.z = bus.out_z;
      o.f = {bus.nan, bus.overflow, bus.underflow, bus.zero, bus.inexact};
      obs_q.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // Round-to-nearest-even from the exact integer product: keep the top 24 bits,
  // compare the discarded remainder against one half.
  function automatic res_t ref_model(input bit sg, input int e_in, input logic [47:0] m,
                                     input bit fn, input bit fi, input bit fz);
    res_t r;
    longint unsigned mm, sig, rem, half;
    int sh, e;
    bit up;
    r.z = 32'h0;
    r.f = 5'b0;
    if (fn) begin
      r.z = 32'h7FC00000; r.f = 5'b10000;
    end else if (fi) begin
      r.z = {sg, 31'h7F800000}; r.f = 5'b01000;
    end else if (fz) begin
      r.z = {sg, 31'h0}; r.f = 5'b00010;
    end else begin
      mm   = 64'(m);
      sh   = m[47] ? 24 : 23;
      e    = e_in + (m[47] ? 1 : 0);
      sig  = mm >> sh;
      rem  = mm & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && sig[0]);
      sig  = sig + 64'(up);
      if (sig >= (64'd1 << 24)) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      if (e >= 255) begin
        r.z = {sg, 31'h7F800000}; r.f = 5'b01001;
      end else if (e <= 0) begin
        r.z = {sg, 31'h0}; r.f = 5'b00111;
      end else begin
        r.z = {sg, 8'(e), sig[22:0]};
        r.f = {4'b0000, rem != 0};
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input bit sg, input int e, input logic [47:0] m,
                        input bit fn, input bit fi, input bit fz);
    bus.in_valid = 1'b1;
    bus.in_sign  = sg;
    bus.in_exp   = 10'(e);
    bus.in_mant  = m;
    bus.in_nan   = fn;
    bus.in_inf   = fi;
    bus.in_zero  = fz;
  endtask

  // Holds the beat until it is accepted; returns just after the accepting edge.
  task automatic send(input bit sg, input int e, input logic [47:0] m,
                      input bit fn, input bit fi, input bit fz);
    int n;
    set_in(sg, e, m, fn, fi, fz);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    chk("accept", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(ref_model(sg, e, m, fn, fi, fz));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    res_t o, x;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_z"}, o.z, x.z);
      chk({tag, "_flags"}, 32'(o.f), 32'(x.f));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    res_t ea;
    logic [23:0] a, b;
    int e, r;
    idle();
    bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_nan = 1'b0; bus.in_inf = 1'b0; bus.in_zero = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_z", bus.out_z, 32'h0);
    chk("rst_flags", 32'({bus.nan, bus.overflow, bus.underflow, bus.zero, bus.inexact}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // 1.5*1.5 with latency check
    send(1'b0, 127, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("lat_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(bus.out_valid), 32'd1);
    chk("lat_z", bus.out_z, 32'h40100000);
    drain("mul15");

    // rounding ties, carry, overflow, underflow, specials
    @(posedge clk); #1;
    send(1'b0, 127, 48'h400000400000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 127, 48'h400000C00000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 254, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    send(1'b1, 0,   48'h400000000000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 127, 48'h900000000000, 1'b1, 1'b1, 1'b0);
    send(1'b1, 127, 48'h900000000000, 1'b0, 1'b0, 1'b1);
    send(1'b1, 3,   48'h800000000000, 1'b0, 1'b1, 1'b0);
    send(1'b0, -125, 48'hFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
    send(1'b0, 253, 48'h7FFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
    idle();
    drain("dir");

    // stall: two beats fill the pipe, third is held off
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    send(1'b0, 130, 48'h912345600000, 1'b0, 1'b0, 1'b0);
    send(1'b1, 100, 48'h5ABCDEF01234, 1'b0, 1'b0, 1'b0);
    ea = exp_q[0];
    set_in(1'b0, 140, 48'hC00000000001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_z", bus.out_z, ea.z);
    end
    @(posedge clk); #1;
    dir_rdy = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(ref_model(1'b0, 140, 48'hC00000000001, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    idle();
    drain("stall");

    // reset while stalled discards both in-flight beats
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    send(1'b0, 120, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 121, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_z", bus.out_z, 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    dir_rdy = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    chk("midrst_no_output", 32'(obs_q.size()), 32'd0);
    chk("midrst_idle_valid", 32'(bus.out_valid), 32'd0);

    // randomized traffic with random backpressure
    @(posedge clk); #1;
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      r = int'($urandom_range(0, 9));
      if (r < 3) e = int'($urandom_range(0, 5)) - 2;
      else if (r < 6) e = 251 + int'($urandom_range(0, 5));
      else e = int'($urandom_range(0, 506)) - 125;
      r = int'($urandom_range(0, 19));
      send(1'($urandom), e, 48'(a) * 48'(b), r == 0, r == 1 || r == 3, r == 2 || r == 3);
    end
    idle();
    drain("rand");
    rnd_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
